// File: rtl/apb_cmd_bridge.sv
// Command-to-APB bridge: runs one bench command as zero, one or two APB transfers to the
// WDT (slot 0) or memory (slot 1), keeps per-slot read data and owns the CPU run flag.
module apb_cmd_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        opcode,
  input  logic [2:0]        opcode_2,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] data_2,
  output logic              cmd_done,
  output logic              cmd_err,
  output logic [DATA_W-1:0] prdata_0,
  output logic [DATA_W-1:0] prdata_1,
  output logic [1:0]        psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata_s0,
  input  logic [DATA_W-1:0] prdata_s1,
  input  logic              pready_s0,
  input  logic              pready_s1,
  input  logic              pslverr_s0,
  input  logic              pslverr_s1,
  input  logic              wdt_timeout,
  output logic              wdt_trigger_reset,
  input  logic              cpudone,
  output logic              run
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_READ  = 3'b010;
  localparam logic [2:0] OP_RAMW  = 3'b011;
  localparam logic [2:0] OP_RUN   = 3'b100;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, SETUP2, ACCESS2, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op_q, op2_q;
  logic [ADDR_W-1:0] addr_q, addr2_q;
  logic [DATA_W-1:0] data_q, data2_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              err_q;
  logic              accept, active, phase2, in_access, slot;
  logic              sel_ready, sel_err, expired;

  assign cmd_ready = (state == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_done  = (state == DONE);
  assign cmd_err   = (state == DONE) && err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    active    = (state != IDLE) && (state != DONE);
    phase2    = (state == SETUP2) || (state == ACCESS2);
    in_access = (state == ACCESS) || (state == ACCESS2);
    slot      = phase2 ? addr2_q[ADDR_W-1] : addr_q[ADDR_W-1];
    sel_ready = slot ? pready_s1 : pready_s0;
    sel_err   = slot ? pslverr_s1 : pslverr_s0;
    expired   = in_access && !sel_ready && (wait_cnt == LAST_WAIT);
    psel      = '0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    // APB fields are driven only while a slave is selected, so IDLE/DONE show zeros
    if (active) begin
      psel    = slot ? 2'b10 : 2'b01;
      penable = in_access;
      pwrite  = phase2 || (op_q != OP_READ);
      paddr   = phase2 ? addr2_q : addr_q;
      pwdata  = phase2 ? data2_q : data_q;
    end
    case (state)
      IDLE:    if (accept)
                 state_nxt = (opcode inside {OP_WRITE, OP_READ, OP_RAMW}) ? SETUP : DONE;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (sel_ready)
                 state_nxt = (op_q == OP_RAMW && op2_q == OP_WRITE && !sel_err) ? SETUP2 : DONE;
               else if (expired)
                 state_nxt = DONE;
      SETUP2:  state_nxt = ACCESS2;
      ACCESS2: if (sel_ready || expired) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt          <= '0;
      err_q             <= 1'b0;
      prdata_0          <= '0;
      prdata_1          <= '0;
      run               <= 1'b0;
      wdt_trigger_reset <= 1'b0;
    end else begin
      wdt_trigger_reset <= wdt_timeout;
      if (cpudone)                           run <= 1'b0;
      else if (accept && opcode == OP_RUN)   run <= 1'b1;
      wait_cnt <= (in_access && !sel_ready) ? wait_cnt + 1'b1 : '0;
      // opcode-level errors are known at acceptance; bus errors accumulate afterwards
      if (accept)
        err_q <= (opcode > OP_RUN) || (opcode == OP_RAMW && opcode_2 != OP_WRITE);
      else if (expired || (in_access && sel_ready && sel_err))
        err_q <= 1'b1;
      if (state == ACCESS && sel_ready && !sel_err && op_q == OP_READ) begin
        if (slot) prdata_1 <= prdata_s1;
        else      prdata_0 <= prdata_s0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q    <= opcode;
      op2_q   <= opcode_2;
      addr_q  <= addr;
      addr2_q <= addr_2;
      data_q  <= data;
      data2_q <= data_2;
    end
  end

endmodule

// File: tb/tb_apb_cmd_bridge.sv
// Bench for apb_cmd_bridge: directed vector table, hand-written corner sequences and
// randomized commands checked against a latency/result model of the command rules.
module tb_apb_cmd_bridge;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              clk, reset, cmd_valid, cmd_ready;
  logic [2:0]        opcode, opcode_2;
  logic [ADDR_W-1:0] addr, addr_2, paddr;
  logic [DATA_W-1:0] data, data_2, pwdata, prdata_0, prdata_1, prdata_s0, prdata_s1;
  logic              cmd_done, cmd_err, penable, pwrite;
  logic [1:0]        psel;
  logic              pready_s0, pready_s1, pslverr_s0, pslverr_s1;
  logic              wdt_timeout, wdt_trigger_reset, cpudone, run;

  apb_cmd_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .opcode(opcode), .opcode_2(opcode_2), .addr(addr), .addr_2(addr_2),
    .data(data), .data_2(data_2), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .prdata_0(prdata_0), .prdata_1(prdata_1), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata_s0(prdata_s0), .prdata_s1(prdata_s1),
    .pready_s0(pready_s0), .pready_s1(pready_s1),
    .pslverr_s0(pslverr_s0), .pslverr_s1(pslverr_s1),
    .wdt_timeout(wdt_timeout), .wdt_trigger_reset(wdt_trigger_reset),
    .cpudone(cpudone), .run(run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [2:0]  op2;
    logic [7:0]  addr2;
    logic [31:0] data2;
    int          waits;
    logic        slverr;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          exp_lat;
    logic        exp_err;
    int          exp_ntr;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] m_prd0, m_prd1;
  logic        m_run;
  vec_t        tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [7:0] a, input logic [31:0] d,
                              input logic [2:0] op2, input logic [7:0] a2, input logic [31:0] d2,
                              input int waits, input logic slv, input logic [31:0] rd1,
                              input int lat, input logic err, input int ntr);
    vec_t v;
    v.op = op; v.addr = a; v.data = d; v.op2 = op2; v.addr2 = a2; v.data2 = d2;
    v.waits = waits; v.slverr = slv; v.rd1 = rd1; v.rd0 = rd1 ^ 32'hFFFF0000;
    v.exp_lat = lat; v.exp_err = err; v.exp_ntr = ntr;
    return v;
  endfunction

  // Latency = acceptance cycle + per transfer (one SETUP + its ACCESS cycles) + DONE.
  function automatic vec_t model(input vec_t vi);
    vec_t v;
    int planned;
    v = vi;
    v.exp_lat = 1; v.exp_err = 1'b0; v.exp_ntr = 0;
    if (v.op > 3'd4) v.exp_err = 1'b1;
    else if (v.op >= 3'd1 && v.op <= 3'd3) begin
      planned = (v.op == 3'd3 && v.op2 == 3'd1) ? 2 : 1;
      for (int i = 0; i < planned; i++) begin
        if (v.waits >= TIMEOUT) begin
          v.exp_lat += 1 + TIMEOUT;
          v.exp_err = 1'b1;
          break;
        end
        v.exp_lat += 2 + v.waits;
        v.exp_ntr++;
        if (v.slverr) begin
          v.exp_err = 1'b1;
          break;
        end
      end
      if (v.op == 3'd3 && v.op2 != 3'd1) v.exp_err = 1'b1;
    end
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    int   wsel;
    v.op    = 3'($urandom_range(0, 7));
    v.addr  = 8'($urandom);
    v.data  = $urandom;
    v.op2   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd1;
    v.addr2 = 8'($urandom);
    v.data2 = $urandom;
    wsel    = int'($urandom_range(0, 9));
    v.waits = (wsel < 6) ? 0 : (wsel < 8) ? int'($urandom_range(1, 4)) :
              (wsel == 8) ? TIMEOUT - 1 : TIMEOUT + 2;
    v.slverr = ($urandom_range(0, 7) == 0);
    v.rd0   = $urandom;
    v.rd1   = $urandom;
    return model(v);
  endfunction

  // Called on a falling edge with the bridge idle; returns on the falling edge after DONE.
  task automatic run_vec(input string tag, input vec_t v);
    int          cyc, acc, nlog, done_cyc;
    logic        err_seen, has_xfer;
    logic [7:0]  lg_addr[2];
    logic [31:0] lg_data[2];
    logic        lg_wr[2];
    logic [1:0]  lg_psel[2];
    logic [7:0]  ea;
    has_xfer = (v.op >= 3'd1 && v.op <= 3'd3);
    prdata_s0 = v.rd0; prdata_s1 = v.rd1;
    opcode = v.op; addr = v.addr; data = v.data;
    opcode_2 = v.op2; addr_2 = v.addr2; data_2 = v.data2;
    cmd_valid = 1'b1;
    chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    opcode = 3'($urandom); addr = 8'($urandom); data = $urandom;
    opcode_2 = 3'($urandom); addr_2 = 8'($urandom); data_2 = $urandom;
    cyc = 0; acc = 0; nlog = 0; done_cyc = 0; err_seen = 1'b0;
    while (cyc < 64 && done_cyc == 0) begin
      @(negedge clk);
      cyc++;
      pready_s0 = 1'b0; pready_s1 = 1'b0; pslverr_s0 = 1'b0; pslverr_s1 = 1'b0;
      if (has_xfer && cyc == 1) begin
        chk({tag, ".setup_psel"}, 64'(psel), 64'(v.addr[7] ? 2'b10 : 2'b01));
        chk({tag, ".setup_penable"}, 64'(penable), 64'd0);
      end
      if (has_xfer && cyc == 2) chk({tag, ".access_penable"}, 64'(penable), 64'd1);
      if (cmd_done) begin
        done_cyc = cyc;
        err_seen = cmd_err;
      end else if (psel != 2'b00) begin
        if (!penable) acc = 0;
        else begin
          acc++;
          if (acc > v.waits) begin
            pready_s0 = psel[0]; pready_s1 = psel[1];
            pslverr_s0 = psel[0] & v.slverr; pslverr_s1 = psel[1] & v.slverr;
            if (nlog < 2) begin
              lg_addr[nlog] = paddr; lg_data[nlog] = pwdata;
              lg_wr[nlog] = pwrite; lg_psel[nlog] = psel;
            end
            nlog++;
          end
        end
      end
    end
    if (v.op == 3'd2 && v.waits < TIMEOUT && !v.slverr) begin
      if (v.addr[7]) m_prd1 = v.rd1;
      else           m_prd0 = v.rd0;
    end
    if (v.op == 3'd4) m_run = 1'b1;
    if (done_cyc == 0) chk({tag, ".done_seen"}, 64'd0, 64'd1);
    else begin
      chk({tag, ".latency"}, 64'(done_cyc), 64'(v.exp_lat));
      chk({tag, ".cmd_err"}, 64'(err_seen), 64'(v.exp_err));
    end
    chk({tag, ".transfers"}, 64'(nlog), 64'(v.exp_ntr));
    for (int i = 0; i < 2; i++) begin
      if (i < nlog && i < v.exp_ntr) begin
        ea = (i == 0) ? v.addr : v.addr2;
        chk({tag, ".paddr"}, 64'(lg_addr[i]), 64'(ea));
        chk({tag, ".psel"}, 64'(lg_psel[i]), 64'(ea[7] ? 2'b10 : 2'b01));
        chk({tag, ".pwrite"}, 64'(lg_wr[i]), 64'((i == 1) || (v.op != 3'd2)));
        if (i == 1 || v.op != 3'd2)
          chk({tag, ".pwdata"}, 64'(lg_data[i]), 64'((i == 0) ? v.data : v.data2));
      end
    end
    chk({tag, ".prdata_0"}, 64'(prdata_0), 64'(m_prd0));
    chk({tag, ".prdata_1"}, 64'(prdata_1), 64'(m_prd1));
    chk({tag, ".run"}, 64'(run), 64'(m_run));
    @(negedge clk);
  endtask

  initial begin
    int dcount;
    vec_t rv;
    reset = 1'b0; cmd_valid = 1'b0; opcode = '0; opcode_2 = '0; addr = '0; addr_2 = '0;
    data = '0; data_2 = '0; prdata_s0 = '0; prdata_s1 = '0; pready_s0 = 1'b0;
    pready_s1 = 1'b0; pslverr_s0 = 1'b0; pslverr_s1 = 1'b0; wdt_timeout = 1'b0;
    cpudone = 1'b0;
    m_prd0 = '0; m_prd1 = '0; m_run = 1'b0;

    //         op      addr   data          op2     addr2  data2  waits slv rd1          lat err ntr
    tbl[0]  = mk(3'd2, 8'h84, 32'h0,        3'd0, 8'h00, 32'h0,  0,   0, 32'hDEADBEEF, 3,  0, 1);
    tbl[1]  = mk(3'd1, 8'h04, 32'h5A,       3'd0, 8'h00, 32'h0,  3,   0, 32'h0,        6,  0, 1);
    tbl[2]  = mk(3'd3, 8'h80, 32'h11,       3'd1, 8'h81, 32'h22, 0,   0, 32'h0,        5,  0, 2);
    tbl[3]  = mk(3'd3, 8'h80, 32'h11,       3'd2, 8'h81, 32'h22, 0,   0, 32'h0,        3,  1, 1);
    tbl[4]  = mk(3'd2, 8'h04, 32'h0,        3'd0, 8'h00, 32'h0,  100, 0, 32'h11111111, 18, 1, 0);
    tbl[5]  = mk(3'd2, 8'h10, 32'h0,        3'd0, 8'h00, 32'h0,  0,   0, 32'h12345678, 3,  0, 1);
    tbl[6]  = mk(3'd2, 8'h90, 32'h0,        3'd0, 8'h00, 32'h0,  0,   1, 32'hBAD0BAD0, 3,  1, 1);
    tbl[7]  = mk(3'd0, 8'h12, 32'h77,       3'd0, 8'h00, 32'h0,  0,   0, 32'h0,        1,  0, 0);
    tbl[8]  = mk(3'd6, 8'h12, 32'h77,       3'd0, 8'h00, 32'h0,  0,   0, 32'h0,        1,  1, 0);
    tbl[9]  = mk(3'd4, 8'h00, 32'h0,        3'd0, 8'h00, 32'h0,  0,   0, 32'h0,        1,  0, 0);
    tbl[10] = mk(3'd3, 8'h05, 32'hAA,       3'd1, 8'h85, 32'hBB, 2,   0, 32'h0,        9,  0, 2);
    tbl[11] = mk(3'd2, 8'h90, 32'h0,        3'd0, 8'h00, 32'h0,  15,  0, 32'h0F0F0F0F, 18, 0, 1);
    tbl[12] = mk(3'd3, 8'h80, 32'h33,       3'd1, 8'h81, 32'h44, 100, 0, 32'h0,        18, 1, 0);

    // reset state
    #1 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("rst.cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst.psel", 64'(psel), 64'd0);
    chk("rst.penable_pwrite", 64'({penable, pwrite}), 64'd0);
    chk("rst.paddr_pwdata", 64'({paddr, pwdata}), 64'd0);
    chk("rst.prdata", 64'({prdata_0, prdata_1}), 64'd0);
    chk("rst.done_err_run_wdt", 64'({cmd_done, cmd_err, run, wdt_trigger_reset}), 64'd0);
    reset = 1'b0;
    #1 chk("rst.cmd_ready_after", 64'(cmd_ready), 64'd1);
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

    // cpudone clears run
    cpudone = 1'b1;
    @(posedge clk); #1 cpudone = 1'b0;
    @(negedge clk);
    chk("cpudone.run", 64'(run), 64'd0);
    m_run = 1'b0;

    // RUN accepted on the same edge as cpudone: clear wins
    opcode = 3'd4; cmd_valid = 1'b1; cpudone = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0; cpudone = 1'b0;
    @(negedge clk);
    chk("run_vs_cpudone.run", 64'(run), 64'd0);
    chk("run_vs_cpudone.done", 64'(cmd_done), 64'd1);
    @(negedge clk);

    // watchdog request passes through one register stage
    wdt_timeout = 1'b1;
    #1 chk("wdt.before_edge", 64'(wdt_trigger_reset), 64'd0);
    @(negedge clk);
    chk("wdt.after_edge", 64'(wdt_trigger_reset), 64'd1);
    wdt_timeout = 1'b0;
    @(negedge clk);
    chk("wdt.released", 64'(wdt_trigger_reset), 64'd0);

    // reset during ACCESS
    opcode = 3'd2; addr = 8'h04; cmd_valid = 1'b1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("midrst.penable_before", 64'(penable), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst.psel", 64'(psel), 64'd0);
    chk("midrst.penable", 64'(penable), 64'd0);
    chk("midrst.cmd_ready", 64'(cmd_ready), 64'd0);
    dcount = 0;
    @(negedge clk);
    if (cmd_done) dcount++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cmd_done) dcount++;
    end
    chk("midrst.no_done", 64'(dcount), 64'd0);
    chk("midrst.cmd_ready_after", 64'(cmd_ready), 64'd1);
    chk("midrst.prdata_cleared", 64'({prdata_0, prdata_1}), 64'd0);
    m_prd0 = '0; m_prd1 = '0; m_run = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rv = rand_vec();
      run_vec($sformatf("rnd%0d", i), rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/apb_cmd_bridge.md
# apb_cmd_bridge

DUT-side responder for the bench command interface of the simple processor / APB peripheral subsystem. It accepts one command per handshake (opcode, address, data, plus a second word for RAM writes) and turns it into APB master transfers to two slaves: slot 0 is the watchdog timer, slot 1 is the memory module. It returns registered read data per slot and forwards the watchdog reset request. It also owns the CPU `run` flag, which is set by command and cleared by `cpudone`.

## Interface
- ADDR_W, 8: width of `addr`, `addr_2` and `paddr`; `addr[ADDR_W-1]` selects the slave.
- DATA_W, 32: width of all data buses.
- TIMEOUT, 16: maximum ACCESS cycles without `pready` before the transfer is aborted (minimum 2).

- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge idle; command accepted when `cmd_valid && cmd_ready`.
- opcode, opcode_2  in  3  command opcodes.
- addr, addr_2  in  ADDR_W  target addresses.
- data, data_2  in  DATA_W  write data.
- cmd_done  out  1  one-cycle pulse when a command completes.
- cmd_err  out  1  one-cycle pulse with `cmd_done`; flags a timeout, `pslverr`, an illegal opcode or an illegal `opcode_2`.
- prdata_0, prdata_1  out  DATA_W  last read data from slot 0 / slot 1.
- psel  out  2  one-hot APB select (bit0 = WDT, bit1 = memory).
- penable, pwrite  out  1  APB control.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata_s0, prdata_s1  in  DATA_W  slave read data.
- pready_s0, pready_s1, pslverr_s0, pslverr_s1  in  1  slave responses; only the selected slave's response is sampled.
- wdt_timeout  in  1  WDT reset request.
- wdt_trigger_reset  out  1  `wdt_timeout` registered by one cycle.
- cpudone  in  1  CPU finished.
- run  out  1  CPU run enable.

## Operation
- Opcodes:
  - 3'b000 NOP: completes with no APB traffic.
  - 3'b001 WRITE: one write of `data` to `addr`.
  - 3'b010 READ: one read from `addr`.
  - 3'b011 RAM_WRITE: write of `data` to `addr`, then a write of `data_2` to `addr_2`.
  - 3'b100 RUN: sets `run`.
  - 3'b101–3'b111: illegal; completes immediately with `cmd_err`.
- RAM_WRITE requires `opcode_2 == 3'b001`. Otherwise the first write is still performed, the second is skipped, and `cmd_err` is pulsed.
- All command fields are captured on acceptance; later input changes are ignored.
- FSM states: IDLE, SETUP, ACCESS, SETUP2, ACCESS2, DONE.
  - IDLE → SETUP on acceptance of WRITE, READ or RAM_WRITE.
  - IDLE → DONE on acceptance of NOP, RUN or an illegal opcode.
  - SETUP → ACCESS.
  - ACCESS → SETUP2 on `pready` for RAM_WRITE with legal `opcode_2` and no error.
  - ACCESS → DONE on `pready` in all other cases, or on timeout.
  - SETUP2 → ACCESS2 → DONE.
  - DONE → IDLE.
- `pslverr` is sampled with `pready`. Any error skips the second RAM_WRITE transfer.
- A READ updates `prdata_0` or `prdata_1` (chosen by `addr[ADDR_W-1]`) on the completing edge, only if `pslverr` is 0; on timeout it keeps its old value.
- `run`: set by RUN, cleared by `cpudone`. If both happen on the same edge, clear wins.

## Timing
- Reset values: IDLE; `cmd_ready`=0 while `reset` is high, then 1; all other outputs 0 (`psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `prdata_0`, `prdata_1`, `cmd_done`, `cmd_err`, `wdt_trigger_reset`, `run`).
- `cmd_ready` is high only in IDLE.
- Command accepted at edge N:
  - SETUP during cycle N+1: `psel` set, `penable`=0, and `paddr`/`pwrite`/`pwdata` stable.
  - ACCESS from cycle N+2: `penable`=1.
  - `psel`, `paddr`, `pwrite` and `pwdata` stay constant from SETUP to the end of ACCESS.
- With zero wait states, `cmd_done` is high in cycle N+3. Each wait cycle adds one.
- RAM_WRITE with zero wait states: `cmd_done` is high in cycle N+5; `psel` drops for no cycle between the two transfers.
- Timeout: after TIMEOUT consecutive ACCESS cycles with `pready`=0, `psel`/`penable` drop on the next edge; `cmd_done` and `cmd_err` then pulse in DONE.
- `psel` and `penable` are 0 in IDLE and DONE.
- Reset asserted mid-transfer forces IDLE and the reset values asynchronously; no completion pulse is produced.

## Test plan
- Reset, then READ `addr`=8'h84 with `prdata_s1`=32'hDEADBEEF and zero waits → `psel`=2'b10 in N+1, `penable` in N+2, `prdata_1`=32'hDEADBEEF and `cmd_done` in N+3, `prdata_0` still 0.
- WRITE `addr`=8'h04, `data`=32'h5A with `pready_s0` held low 3 cycles → `pwrite`=1, `paddr`=8'h04; `cmd_done` in N+6 with `cmd_err`=0.
- RAM_WRITE (8'h80, 32'h11) then (8'h81, 32'h22) with `opcode_2`=3'b001 → two back-to-back writes, `cmd_done` in N+5; repeat with `opcode_2`=3'b010 → only the first write occurs and `cmd_err` pulses.
- READ slot 0 with `pready_s0` stuck at 0 → abort after 16 ACCESS cycles, `cmd_err`=1, `prdata_0` unchanged.
- RUN → `run`=1 in N+1; `cpudone` pulse → `run`=0; RUN accepted on the same edge as `cpudone` → `run` stays 0.
- `wdt_timeout` pulse → `wdt_trigger_reset` follows one cycle later; `reset` asserted during an ACCESS → `psel`=0 immediately and no `cmd_done`.
